// File: rtl/csk_pkg.sv
// -----------------------------------------------------------------------------
// csk_pkg
// Shared definitions for the pipelined carry-skip adder/subtractor:
//   - default parameter values (WIDTH 32, BLK 4, STAGES 2)
//   - derived constants: csk_nblk() = WIDTH/BLK, csk_bps() = NBLK/STAGES
//   - csk_legal(): the parameter legality check used at elaboration
// Optional build macro used by the top level: CSK_STATUS_FLAGS_EN.
// -----------------------------------------------------------------------------
package csk_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int BLK_DEF    = 4;
    localparam int STAGES_DEF = 2;

    // Number of carry-skip blocks across the full operand width.
    function automatic int csk_nblk(input int width, input int blk);
        return width / blk;
    endfunction

    // Blocks handled by each pipeline stage.
    function automatic int csk_bps(input int width, input int blk, input int stages);
        return (width / blk) / stages;
    endfunction

    // Width must split into whole blocks and blocks must split evenly over stages.
    function automatic bit csk_legal(input int width, input int blk, input int stages);
        return (blk > 0) && (stages > 0) && (width >= blk) &&
               (width % blk == 0) && ((width / blk) % stages == 0);
    endfunction

endpackage

// File: rtl/csk_skip_block.sv
// -----------------------------------------------------------------------------
// csk_skip_block
// One BLK-bit carry-skip block: internal ripple carry plus the skip mux that
// forwards the block carry-in straight to the carry-out when every bit
// propagates.
// Ports:
//   a, b  in  BLK  operand slices (b already inverted for subtract)
//   cin   in  1    block carry-in
//   sum   out BLK  block sum slice
//   cout  out 1    block carry-out (skip or ripple)
// -----------------------------------------------------------------------------
module csk_skip_block
    import csk_pkg::*;
#(
    parameter int BLK = BLK_DEF
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout
);

    logic [BLK-1:0] p;
    logic           ripple;

    assign p = a ^ b;

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < BLK; i++) begin
            sum[i] = p[i] ^ c;
            c      = (a[i] & b[i]) | (p[i] & c);
        end
        ripple = c;
    end

    // When the whole block propagates, the ripple result equals cin anyway;
    // the mux only shortens the critical path through this block.
    assign cout = (&p) ? cin : ripple;

endmodule

// File: rtl/csk_adder_pipe.sv
// -----------------------------------------------------------------------------
// csk_adder_pipe
// Pipelined carry-skip adder/subtractor with valid/ready handshake and full
// backpressure. STAGES register stages, each resolving BPS skip blocks; the
// carry between stages is registered, and not-yet-used operand bits travel
// with the partial sum.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input beat handshake
//   in_a, in_b          operands (WIDTH)
//   in_cin              carry-in, ignored when in_sub=1
//   in_sub              1: A-B, 0: A+B+cin
//   out_valid/out_ready result handshake
//   out_sum, out_cout   result and MSB carry (subtract: 1 = no borrow)
//   out_ovf, out_zero   signed overflow / zero result, only when
//                       CSK_STATUS_FLAGS_EN is defined
// -----------------------------------------------------------------------------
module csk_adder_pipe
    import csk_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int BLK    = BLK_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CSK_STATUS_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_zero
`endif
);

    localparam int NBLK = csk_nblk(WIDTH, BLK);
    localparam int BPS  = csk_bps(WIDTH, BLK, STAGES);
    localparam int SW   = BPS * BLK;
    localparam int L    = STAGES - 1;
    localparam logic [WIDTH-1:0] ONES = '1;

    if (!csk_legal(WIDTH, BLK, STAGES)) begin : g_illegal
        $error("csk_adder_pipe: WIDTH must be a multiple of BLK and NBLK a multiple of STAGES");
    end

    logic                          en;
    logic [STAGES-1:0]             vld_p, c_p;
    logic [STAGES-1:0][WIDTH-1:0]  a_p, b_p, sum_p;

    // Per-stage combinational view: what stage k sees and what it produces.
    logic [STAGES-1:0]             st_v, st_c, st_cout;
    logic [STAGES-1:0][WIDTH-1:0]  st_a, st_b, st_s, st_sum;
    logic [WIDTH-1:0]              blk_sum;

    // One global enable: the whole pipe advances or the whole pipe holds.
    assign en       = ~vld_p[L] | out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - SW)) << (k * SW);

        if (k == 0) begin : g_first
            assign st_v[k] = in_valid;
            assign st_a[k] = in_a;
            assign st_b[k] = in_sub ? ~in_b : in_b;
            assign st_c[k] = in_sub | in_cin;
            assign st_s[k] = '0;
        end else begin : g_next
            assign st_v[k] = vld_p[k-1];
            assign st_a[k] = a_p[k-1];
            assign st_b[k] = b_p[k-1];
            assign st_c[k] = c_p[k-1];
            assign st_s[k] = sum_p[k-1];
        end

        // Lower slices pass through; this stage's slice is filled in.
        assign st_sum[k]  = (st_s[k] & ~MASK) | (blk_sum & MASK);
        assign st_cout[k] = g_blk[(k + 1) * BPS - 1].cout;
    end

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        localparam int S = i / BPS;
        logic cin;
        logic cout;

        if (i % BPS == 0) begin : g_stage_cin
            assign cin = st_c[S];
        end else begin : g_chain_cin
            assign cin = g_blk[i-1].cout;
        end

        csk_skip_block #(.BLK(BLK)) u_blk (
            .a    (st_a[S][i*BLK +: BLK]),
            .b    (st_b[S][i*BLK +: BLK]),
            .cin  (cin),
            .sum  (blk_sum[i*BLK +: BLK]),
            .cout (cout)
        );
    end

    // ---- stage registers (stage k output = register index k) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            c_p   <= '0;
            a_p   <= '0;
            b_p   <= '0;
            sum_p <= '0;
        end else if (en) begin
            vld_p <= st_v;
            c_p   <= st_cout;
            a_p   <= st_a;
            b_p   <= st_b;
            sum_p <= st_sum;
        end
    end

    assign out_valid = vld_p[L];
    assign out_sum   = sum_p[L];
    assign out_cout  = c_p[L];

`ifdef CSK_STATUS_FLAGS_EN
    logic ovf_p, zero_p;

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_p  <= 1'b0;
            zero_p <= 1'b0;
        end else if (en) begin
            ovf_p  <= st_a[L][WIDTH-1] ^ st_b[L][WIDTH-1] ^ st_sum[L][WIDTH-1] ^ st_cout[L];
            zero_p <= ~|st_sum[L];
        end
    end

    assign out_ovf  = ovf_p;
    assign out_zero = zero_p;
`endif

    // Operand bits already consumed by earlier stages are carried but unread.
    logic unused_ops;
    assign unused_ops = ^{a_p, b_p};

endmodule
